// File: rtl/nv_nvdla_ssync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_ssync_pkg
//  Description : Shared constants and helpers for the multi-channel level
//                synchroniser (nv_nvdla_ssync_mc / nv_nvdla_ssync_ch).
//  Revision    : 1.0 - initial release
// ============================================================================
package nv_nvdla_ssync_pkg;

   // Legal synchroniser flop-chain depth range
   localparam int SSYNC_STAGES_MIN = 2;
   localparam int SSYNC_STAGES_MAX = 4;

   // Width of the per-channel stability counter; it must hold FILTER_CNT and
   // is never narrower than one bit, even when filtering is disabled.
   function automatic int ssync_cnt_w(input int filter_cnt);
      int w;
      w = 1;
      while ((2 ** w) < (filter_cnt + 1)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage : nv_nvdla_ssync_pkg
`default_nettype wire

// File: rtl/nv_nvdla_ssync_ch.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_ssync_ch
//  Description : One synchroniser channel: flop chain, stability filter,
//                filtered level output and registered rise/fall pulses.
//                Optional sticky rise flag when NVDLA_SSYNC_STICKY_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module nv_nvdla_ssync_ch
   import nv_nvdla_ssync_pkg::*;
#(
   parameter int   STAGES     = 2,
   parameter logic RST_VAL    = 1'b0,
   parameter int   FILTER_CNT = 0
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic sync_i,
`ifdef NVDLA_SSYNC_STICKY_EN
   input  logic sticky_clr_i,
   output logic sticky_o,
`endif
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = ssync_cnt_w(FILTER_CNT);
   localparam logic [CW-1:0] FILT_MAX = CW'(FILTER_CNT);

   // First stage is the metastability-capturing flop; CAR tools key on the
   // attribute and the _meta_ name. The remaining stages live in the tail.
   (* ASYNC_REG = "TRUE" *) logic sync_meta_q;
   (* ASYNC_REG = "TRUE" *) logic [STAGES-2:0] sync_tail_q;
   logic [STAGES-2:0] sync_tail_d;

   logic          sync_s;   // last chain stage, the synchronised sample
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   assign sync_s = sync_tail_q[STAGES-2];

   // Shift the tail of the chain by one stage
   always_comb begin
      sync_tail_d    = sync_tail_q;
      sync_tail_d[0] = sync_meta_q;
      for (int k = 1; k < STAGES - 1; k++) begin
         sync_tail_d[k] = sync_tail_q[k-1];
      end
   end

   // Synchroniser chain; never bypassed or gated, only reset to RST_VAL
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_meta_q <= RST_VAL;
         sync_tail_q <= {(STAGES-1){RST_VAL}};
      end else begin
         sync_meta_q <= sync_i;
         sync_tail_q <= sync_tail_d;
      end
   end

   // Stability filter: the sample must differ from the output for
   // FILTER_CNT+1 consecutive edges before the output follows it
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == FILT_MAX) begin
         level_d = sync_s;
         cnt_d   = '0;
         rise_d  = sync_s;
         fall_d  = ~sync_s;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Filtered level, counter and edge pulses
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         level_q <= RST_VAL;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign sync_o = level_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

`ifdef NVDLA_SSYNC_STICKY_EN
   logic sticky_q, sticky_d;

   // Sticky flag follows the registered rise pulse; set wins over clear
   always_comb begin
      sticky_d = rise_q | (sticky_q & ~sticky_clr_i);
   end

   // Sticky flag register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_o = sticky_q;
`endif

endmodule : nv_nvdla_ssync_ch
`default_nettype wire

// File: rtl/nv_nvdla_ssync_mc.sv
`default_nettype none
// ============================================================================
//  Module      : nv_nvdla_ssync_mc
//  Description : Multi-channel synchroniser for asynchronous quasi-static
//                level inputs into the o_clk domain, with per-channel glitch
//                filter and rise/fall event pulses. Channels are independent;
//                not for multi-bit buses. Macro NVDLA_SSYNC_STICKY_EN adds
//                sticky rise flags (sticky_clr_i / sticky_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module nv_nvdla_ssync_mc
   import nv_nvdla_ssync_pkg::*;
#(
   parameter int               WIDTH      = 1,
   parameter int               STAGES     = 2,
   parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}},
   parameter int               FILTER_CNT = 0
) (
   input  logic             o_clk,
   input  logic             o_rstn,
   input  logic [WIDTH-1:0] sync_i,
`ifdef NVDLA_SSYNC_STICKY_EN
   input  logic [WIDTH-1:0] sticky_clr_i,
   output logic [WIDTH-1:0] sticky_o,
`endif
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             chg_o
);

   // Reject illegal configurations at elaboration
   if ((STAGES < SSYNC_STAGES_MIN) || (STAGES > SSYNC_STAGES_MAX)) begin : g_bad_stages
      $error("nv_nvdla_ssync_mc: STAGES=%0d outside legal range %0d..%0d",
             STAGES, SSYNC_STAGES_MIN, SSYNC_STAGES_MAX);
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("nv_nvdla_ssync_mc: WIDTH must be at least 1");
   end
   if (FILTER_CNT < 0) begin : g_bad_filter
      $error("nv_nvdla_ssync_mc: FILTER_CNT must be non-negative");
   end

   // One independent channel per input bit
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      nv_nvdla_ssync_ch #(
         .STAGES     (STAGES),
         .RST_VAL    (RST_VAL[i]),
         .FILTER_CNT (FILTER_CNT)
      ) u_ch (
         .clk_i        (o_clk),
         .rstn_i       (o_rstn),
         .sync_i       (sync_i[i]),
`ifdef NVDLA_SSYNC_STICKY_EN
         .sticky_clr_i (sticky_clr_i[i]),
         .sticky_o     (sticky_o[i]),
`endif
         .sync_o       (sync_o[i]),
         .rise_o       (rise_o[i]),
         .fall_o       (fall_o[i])
      );
   end

   // Any channel event this cycle; built from registered pulses only
   always_comb begin
      chg_o = |(rise_o | fall_o);
   end

endmodule : nv_nvdla_ssync_mc
`default_nettype wire

// File: tb/tb_nv_nvdla_ssync_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nv_nvdla_ssync_mc
//  Description : Directed self-checking bench for nv_nvdla_ssync_mc using
//                four differently parameterised instances on one clock.
//                Sticky checks compile in with NVDLA_SSYNC_STICKY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_ssync_mc;

   logic clk;
   logic rstn;

   // A: reset value test (WIDTH=4, STAGES=2, RST_VAL=1010, no filter)
   logic [3:0] sync_a, so_a, ri_a, fa_a;
   logic       chg_a;
   // B: latency / simultaneous / sticky (WIDTH=8, STAGES=3, no filter)
   logic [7:0] sync_b, so_b, ri_b, fa_b;
   logic       chg_b;
   // C: filter (WIDTH=4, STAGES=2, FILTER_CNT=3)
   logic [3:0] sync_c, so_c, ri_c, fa_c;
   logic       chg_c;
   // D: mid-filter reset (WIDTH=2, STAGES=2, FILTER_CNT=5)
   logic [1:0] sync_d, so_d, ri_d, fa_d;
   logic       chg_d;
`ifdef NVDLA_SSYNC_STICKY_EN
   logic [3:0] clr_a, st_a;
   logic [7:0] clr_b, st_b;
   logic [3:0] clr_c, st_c;
   logic [1:0] clr_d, st_d;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   nv_nvdla_ssync_mc #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b1010), .FILTER_CNT(0)) dut_a (
      .o_clk(clk), .o_rstn(rstn), .sync_i(sync_a),
`ifdef NVDLA_SSYNC_STICKY_EN
      .sticky_clr_i(clr_a), .sticky_o(st_a),
`endif
      .sync_o(so_a), .rise_o(ri_a), .fall_o(fa_a), .chg_o(chg_a));

   nv_nvdla_ssync_mc #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00), .FILTER_CNT(0)) dut_b (
      .o_clk(clk), .o_rstn(rstn), .sync_i(sync_b),
`ifdef NVDLA_SSYNC_STICKY_EN
      .sticky_clr_i(clr_b), .sticky_o(st_b),
`endif
      .sync_o(so_b), .rise_o(ri_b), .fall_o(fa_b), .chg_o(chg_b));

   nv_nvdla_ssync_mc #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b0000), .FILTER_CNT(3)) dut_c (
      .o_clk(clk), .o_rstn(rstn), .sync_i(sync_c),
`ifdef NVDLA_SSYNC_STICKY_EN
      .sticky_clr_i(clr_c), .sticky_o(st_c),
`endif
      .sync_o(so_c), .rise_o(ri_c), .fall_o(fa_c), .chg_o(chg_c));

   nv_nvdla_ssync_mc #(.WIDTH(2), .STAGES(2), .RST_VAL(2'b00), .FILTER_CNT(5)) dut_d (
      .o_clk(clk), .o_rstn(rstn), .sync_i(sync_d),
`ifdef NVDLA_SSYNC_STICKY_EN
      .sticky_clr_i(clr_d), .sticky_o(st_d),
`endif
      .sync_o(so_d), .rise_o(ri_d), .fall_o(fa_d), .chg_o(chg_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Hold reset with inputs opposite to the reset value
      for (int t = 0; t < 3; t++) begin
         tick();
         n_checks++;
         if (so_a !== 4'b1010 || ri_a !== 4'b0000 || fa_a !== 4'b0000 || chg_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold t=%0d sync_o=%b rise=%b fall=%b chg=%b expected 1010/0000/0000/0",
                     t, so_a, ri_a, fa_a, chg_a);
         end
      end
      n_checks++;
      if (so_b !== 8'h00 || so_c !== 4'h0 || so_d !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_others b=%h c=%h d=%b expected 00/0/00", so_b, so_c, so_d);
      end
      rstn = 1'b1;
      // Release: update lands on edge STAGES+1 = 3
      for (int t = 1; t <= 4; t++) begin
         tick();
         n_checks++;
         if (t < 3) begin
            if (so_a !== 4'b1010 || ri_a !== 4'b0000 || fa_a !== 4'b0000 || chg_a !== 1'b0) begin
               n_fail++;
               $display("FAIL release_wait t=%0d sync_o=%b rise=%b fall=%b chg=%b expected 1010/0000/0000/0",
                        t, so_a, ri_a, fa_a, chg_a);
            end
         end else if (t == 3) begin
            if (so_a !== 4'b0101 || ri_a !== 4'b0101 || fa_a !== 4'b1010 || chg_a !== 1'b1) begin
               n_fail++;
               $display("FAIL release_update sync_o=%b rise=%b fall=%b chg=%b expected 0101/0101/1010/1",
                        so_a, ri_a, fa_a, chg_a);
            end
         end else begin
            if (so_a !== 4'b0101 || ri_a !== 4'b0000 || fa_a !== 4'b0000 || chg_a !== 1'b0) begin
               n_fail++;
               $display("FAIL release_after sync_o=%b rise=%b fall=%b chg=%b expected 0101/0000/0000/0",
                        so_a, ri_a, fa_a, chg_a);
            end
         end
      end
   endtask

   task automatic test_latency();
      sync_b = 8'h01;
      for (int t = 1; t <= 5; t++) begin
         tick();
         n_checks++;
         if (t < 4) begin
            if (so_b !== 8'h00 || ri_b !== 8'h00 || chg_b !== 1'b0) begin
               n_fail++;
               $display("FAIL latency_wait t=%0d sync_o=%h rise=%h chg=%b expected 00/00/0", t, so_b, ri_b, chg_b);
            end
         end else if (t == 4) begin
            if (so_b !== 8'h01 || ri_b !== 8'h01 || fa_b !== 8'h00 || chg_b !== 1'b1) begin
               n_fail++;
               $display("FAIL latency_edge sync_o=%h rise=%h fall=%h chg=%b expected 01/01/00/1",
                        so_b, ri_b, fa_b, chg_b);
            end
         end else begin
            if (so_b !== 8'h01 || ri_b !== 8'h00 || chg_b !== 1'b0) begin
               n_fail++;
               $display("FAIL latency_pulse_clear sync_o=%h rise=%h chg=%b expected 01/00/0", so_b, ri_b, chg_b);
            end
         end
      end
      // Falling edge also takes four edges and pulses fall_o
      sync_b = 8'h00;
      for (int t = 1; t <= 4; t++) tick();
      n_checks++;
      if (so_b !== 8'h00 || fa_b !== 8'h01 || ri_b !== 8'h00 || chg_b !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_fall sync_o=%h fall=%h rise=%h chg=%b expected 00/01/00/1", so_b, fa_b, ri_b, chg_b);
      end
      for (int t = 0; t < 4; t++) tick();
   endtask

   task automatic test_simultaneous();
      sync_b = 8'hFF;
      for (int t = 1; t <= 5; t++) begin
         tick();
         n_checks++;
         if (t == 4) begin
            if (so_b !== 8'hFF || ri_b !== 8'hFF || fa_b !== 8'h00 || chg_b !== 1'b1) begin
               n_fail++;
               $display("FAIL simul_edge sync_o=%h rise=%h fall=%h chg=%b expected FF/FF/00/1",
                        so_b, ri_b, fa_b, chg_b);
            end
         end else begin
            if (ri_b !== 8'h00 || chg_b !== 1'b0) begin
               n_fail++;
               $display("FAIL simul_quiet t=%0d rise=%h chg=%b expected 00/0", t, ri_b, chg_b);
            end
         end
      end
      sync_b = 8'h00;
      for (int t = 0; t < 8; t++) tick();
   endtask

   task automatic test_filter();
      logic [3:0] exp_s, exp_r, exp_f;
      // Three-cycle excursion on channel 1 must be swallowed
      for (int t = 1; t <= 10; t++) begin
         sync_c = (t <= 3) ? 4'b0010 : 4'b0000;
         tick();
         n_checks++;
         if (so_c !== 4'b0000 || ri_c !== 4'b0000 || fa_c !== 4'b0000 || chg_c !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_glitch t=%0d sync_o=%b rise=%b fall=%b chg=%b expected 0000/0000/0000/0",
                     t, so_c, ri_c, fa_c, chg_c);
         end
      end
      // Four-cycle excursion passes: rise on edge 6, fall on edge 10
      for (int t = 1; t <= 12; t++) begin
         sync_c = (t <= 4) ? 4'b0010 : 4'b0000;
         tick();
         exp_s = (t >= 6 && t <= 9) ? 4'b0010 : 4'b0000;
         exp_r = (t == 6) ? 4'b0010 : 4'b0000;
         exp_f = (t == 10) ? 4'b0010 : 4'b0000;
         n_checks++;
         if (so_c !== exp_s || ri_c !== exp_r || fa_c !== exp_f) begin
            n_fail++;
            $display("FAIL filter_pass t=%0d sync_o=%b rise=%b fall=%b expected %b/%b/%b",
                     t, so_c, ri_c, fa_c, exp_s, exp_r, exp_f);
         end
      end
   endtask

   task automatic test_mid_reset();
      sync_d = 2'b01;
      // Edges 3..5 advance the counter to 3; no update yet
      for (int t = 1; t <= 5; t++) tick();
      n_checks++;
      if (so_d !== 2'b00 || ri_d !== 2'b00) begin
         n_fail++;
         $display("FAIL midrst_pre sync_o=%b rise=%b expected 00/00", so_d, ri_d);
      end
      rstn = 1'b0;
      #1;
      n_checks++;
      if (so_d !== 2'b00 || ri_d !== 2'b00 || fa_d !== 2'b00 || chg_d !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_assert sync_o=%b rise=%b fall=%b chg=%b expected 00/00/00/0", so_d, ri_d, fa_d, chg_d);
      end
      tick();
      tick();
      rstn = 1'b1;
      // Full STAGES+1+FILTER_CNT = 8 edges needed again
      for (int t = 1; t <= 9; t++) begin
         tick();
         n_checks++;
         if (so_d !== ((t >= 8) ? 2'b01 : 2'b00) || ri_d !== ((t == 8) ? 2'b01 : 2'b00)) begin
            n_fail++;
            $display("FAIL midrst_release t=%0d sync_o=%b rise=%b expected %b/%b", t, so_d, ri_d,
                     (t >= 8) ? 2'b01 : 2'b00, (t == 8) ? 2'b01 : 2'b00);
         end
      end
   endtask

`ifdef NVDLA_SSYNC_STICKY_EN
   task automatic test_sticky();
      sync_b = 8'h04;
      for (int t = 1; t <= 4; t++) tick();
      n_checks++;
      if (ri_b !== 8'h04 || st_b[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL sticky_rise rise=%h sticky=%b expected 04/0", ri_b, st_b[2]);
      end
      clr_b = 8'h04;   // clear in the same cycle as rise_o[2]
      tick();
      n_checks++;
      if (st_b[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL sticky_set_wins sticky=%b expected 1", st_b[2]);
      end
      tick();          // clear alone
      n_checks++;
      if (st_b[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL sticky_clear sticky=%b expected 0", st_b[2]);
      end
      clr_b = 8'h00;
   endtask
`endif

   initial begin
      rstn   = 1'b0;
      sync_a = 4'b0101;
      sync_b = 8'h00;
      sync_c = 4'h0;
      sync_d = 2'b00;
`ifdef NVDLA_SSYNC_STICKY_EN
      clr_a = '0;
      clr_b = '0;
      clr_c = '0;
      clr_d = '0;
`endif
      test_reset();
      test_latency();
      test_simultaneous();
      test_filter();
      test_mid_reset();
`ifdef NVDLA_SSYNC_STICKY_EN
      test_sticky();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_nv_nvdla_ssync_mc
`default_nettype wire
